piso_shifter: RTL
=================

Name: piso_shifter

Overview:
Parallel-in, serial-out shifter. It is the unload end of a parallel register: it accepts a WIDTH-bit word through a valid/ready load handshake and emits the word one bit per accepted transfer on a valid/ready serial port. It sits between a parallel datapath register and any bit-serial consumer, such as a UART TX framer or an SPI shifter. A synchronous clear aborts a word in flight.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, sets the shift order: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset_n  input  1  asynchronous active-low reset.
in  input  WIDTH  parallel word to load.
load_valid  input  1  producer asserts that in holds a word.
load_ready  output  1  shifter can accept a word this cycle.
out_bit  output  1  current serial bit.
out_valid  output  1  out_bit is valid.
out_ready  input  1  consumer accepts out_bit this cycle.
clear  input  1  synchronous abort; returns to IDLE.
busy  output  1  a word is in flight (state SHIFT).
done  output  1  one-cycle pulse; registered high for the cycle after the last bit is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, shift register=0, count=0.
  - out_bit=0, out_valid=0, busy=0, done=0.
  - load_ready is forced 0 while reset_n is low, so loads are ignored during reset.
- States: IDLE and SHIFT. count is a down-counter of width clog2(WIDTH).
- IDLE:
  - load_ready=1, out_valid=0, out_bit=0.
  - Load fires when load_valid and load_ready are both 1 at a posedge.
  - On a load: capture in, set count=WIDTH-1, go to SHIFT.
  - The first bit is presented the next cycle. Load-to-first-bit latency is 1 cycle.
- SHIFT:
  - out_valid=1, busy=1.
  - out_bit is bit WIDTH-1 of the shift register if MSB_FIRST=1, otherwise bit 0.
  - On out_valid and out_ready with count>0: shift by one toward the output end (zero-fill), then decrement count.
  - When out_ready=0: out_bit, count and the register hold. out_bit must not change while out_valid is high and unaccepted.
  - Last bit is the cycle where count==0 and out_ready=1:
    - Transfer completes and done pulses high on the next cycle.
    - load_ready=1 combinationally in this cycle only (back-to-back path).
    - If load_valid=1 here, the new word is captured, count=WIDTH-1 and the state stays SHIFT. There is no bubble: the next cycle presents the first bit of the new word.
    - Otherwise go to IDLE.
- load_ready is 0 in SHIFT except in the last-bit cycle above.
- done:
  - High for exactly 1 cycle per completed word.
  - On back-to-back words it pulses once per word, possibly on consecutive boundaries.
  - Never asserted for an aborted word.
- clear (synchronous) has the highest priority over load and shift:
  - Sets state=IDLE, count=0, register=0, done=0.
  - A load presented in the same cycle is dropped; load_ready is 0 while clear=1.
- Word throughput: WIDTH cycles per word with out_ready held at 1.
- Reset asserted mid-word: all outputs drop asynchronously. After release, the state is IDLE with no done pulse.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, load in=0xA5, out_ready=1 -> from the cycle after the load, out_bit sequence is 1,0,1,0,0,1,0,1 over 8 cycles; done pulses once the cycle after the 8th bit; busy is high for exactly 8 cycles.
2. MSB_FIRST=0, in=0xA5 -> sequence is 1,0,1,0,0,1,0,1 (LSB first; 0xA5 is a palindrome). Repeat with 0x01 -> 1,0,0,0,0,0,0,0.
3. Backpressure: in=0x3C with out_ready toggled 1,0,0,1,... -> out_bit holds stable through the stall cycles; the accepted bits are exactly 0,0,1,1,1,1,0,0; done fires only after the 8th accepted bit.
4. Back-to-back: 0xFF then 0x00, with load_valid held high and out_ready=1 -> the second load is accepted in the last-bit cycle; 16 consecutive out_valid cycles produce 8 ones then 8 zeros; done pulses twice, at cycles 9 and 17 relative to the first load.
5. Abort and reset: clear asserted after 3 bits of 0xF0 -> next cycle out_valid=0, busy=0, no done; a new load of 0x81 then serializes correctly. reset_n pulsed low mid-word -> outputs are 0 immediately, and no done after release.

Source files
------------

// File: rtl/piso_shifter_if.sv
// Load and serial handshake bundle for piso_shifter.
// master is the producer/consumer side; slave is the shifter.
interface piso_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic             load_valid;
  logic             load_ready;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             clear;
  logic             busy;
  logic             done;

  modport master (
    output in, load_valid, out_ready, clear,
    input  load_ready, out_bit, out_valid, busy, done
  );

  modport slave (
    input  in, load_valid, out_ready, clear,
    output load_ready, out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter with valid/ready on both sides.
// A word can be reloaded in its own last-bit cycle so words stream with no bubble.
module piso_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  piso_shifter_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             done_q, done_d;

  logic in_shift;
  logic last_bit;
  logic load_fire;

  assign in_shift  = (state_q == StShift);
  assign last_bit  = in_shift && (count_q == '0) && bus.out_ready;
  // Gated by reset_n so a load presented during reset is never acknowledged.
  assign bus.load_ready = reset_n && !bus.clear && ((state_q == StIdle) || last_bit);
  assign load_fire = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = StIdle;
      sreg_d  = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_fire) begin
            state_d = StShift;
            sreg_d  = bus.in;
            count_d = CntLast;
          end
        end
        StShift: begin
          if (bus.out_ready) begin
            if (count_q != '0) begin
              sreg_d  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
              count_d = count_q - 1'b1;
            end else begin
              done_d = 1'b1;
              if (load_fire) begin
                sreg_d  = bus.in;
                count_d = CntLast;
              end else begin
                state_d = StIdle;
                sreg_d  = '0;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.done      = done_q;
  assign bus.out_bit   = in_shift && (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);

endmodule
